// File: rtl/ring_anim_ctrl.sv
// ring_anim_ctrl: debounced control inputs driving a per-frame eased ring-phase accumulator
module ring_anim_ctrl #(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int MAX_STEP        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       speed_in,
  input  logic       dir_in,
  input  logic       pause_in,
  output logic [7:0] anim_offset,
  output logic       cur_dir,
  output logic [2:0] cur_step,
  output logic [1:0] state,
  output logic       busy
);
  typedef enum logic [1:0] {RUN = 2'd0, DECEL = 2'd1, ACCEL = 2'd2} state_t;

  // Control bit order everywhere: [0] speed, [1] dir, [2] pause.
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      acc_q, acc_d;
  logic [2:0][3:0] cnt_q, cnt_d;
  logic [7:0]      off_q, off_d;
  logic            dir_q, dir_d;
  logic [2:0]      step_q, step_d;
  state_t          state_q, state_d;
  logic            armed_q;
  logic            tick;
  logic            new_dir;
  logic [2:0]      target;

  // armed_q keeps a tick that coincides with reset release from advancing anything.
  assign tick    = frame_tick & armed_q;
  assign new_dir = acc_d[1];
  assign target  = acc_q[2] ? 3'd0 : acc_q[0] ? 3'(MAX_STEP) : 3'(MAX_STEP >> 1);

  // Debounce: a synced value must differ from the accepted one for DEBOUNCE_FRAMES ticks in a row.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != acc_q[i]) begin
          if (cnt_q[i] == 4'(DEBOUNCE_FRAMES - 1)) begin
            acc_d[i] = sync2_q[i];
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = 4'd0;
        end
      end
    end
  end

  // Phase advances by the old step; velocity FSM eases to zero before flipping direction.
  always_comb begin
    off_d   = off_q;
    dir_d   = dir_q;
    step_d  = step_q;
    state_d = state_q;
    if (tick) begin
      off_d = dir_q ? off_q - {5'd0, step_q} : off_q + {5'd0, step_q};
      unique case (state_q)
        RUN: begin
          if (new_dir != dir_q) state_d = DECEL;
          else if (step_q < target) step_d = step_q + 3'd1;
          else if (step_q > target) step_d = step_q - 3'd1;
        end
        DECEL: begin
          if (new_dir == dir_q) begin
            state_d = ACCEL;
          end else if (step_q <= 3'd1) begin
            step_d  = 3'd0;
            dir_d   = ~dir_q;
            state_d = ACCEL;
          end else begin
            step_d = step_q - 3'd1;
          end
        end
        ACCEL: begin
          if (new_dir != dir_q) begin
            state_d = DECEL;
          end else if (step_q >= target) begin
            state_d = RUN;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = (step_q + 3'd1 == target) ? RUN : ACCEL;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State registers, including the 2-FF synchronisers on the raw controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= '0;
      state_q <= RUN;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= {pause_in, dir_in, speed_in};
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  assign anim_offset = off_q;
  assign cur_dir     = dir_q;
  assign cur_step    = step_q;
  assign state       = state_q;
  assign busy        = state_q != RUN;
endmodule
